// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: ALU opcodes, default
// datapath widths and the operand forward-select encoding.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 5;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_XOR = 5'b00100,
        ALU_NOR = 5'b00101,
        ALU_SLL = 5'b00110,
        ALU_SRL = 5'b00111,
        ALU_SRA = 5'b01000,
        ALU_SLT = 5'b01001
    } alu_op_e;

    // Which producer an operand is taken from. FWD_EXMEM is the nearer
    // (younger) producer and wins over FWD_MEMWB.
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand producer select: compares one source address against a
// nearer and a farther register-writing producer. Register 0 never matches.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] src_addr,
    input  logic            near_write,
    input  logic [RA_W-1:0] near_addr,
    input  logic            far_write,
    input  logic [RA_W-1:0] far_addr,
    output fwd_sel_t        sel
);

    // Nearer producer has priority since it holds the youngest value.
    always_comb begin
        sel = FWD_REG;
        if (src_addr != '0) begin
            if (near_write && (near_addr == src_addr)) begin
                sel = FWD_EXMEM;
            end else if (far_write && (far_addr == src_addr)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard detection.
// FWD_EN defined: EX/MEM and MEM/WB forwarding muxes, stall only on load-use.
// FWD_EN undefined: no forwarding; stall on any RAW against the EX or EX/MEM
// destination. The MEM/WB capture bypass is present in both builds.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_alu_conf,
    input  logic              id_sign,
    input  logic [RA_W-1:0]   id_rs_addr,
    input  logic [RA_W-1:0]   id_rt_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [RA_W-1:0]   id_wr_addr,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_src1_shamt,
    input  logic              id_src2_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              ext_stall,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [RA_W-1:0]   exmem_wr_addr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RA_W-1:0]   memwb_wr_addr,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [4:0]        alu_conf,
    output logic              alu_sign,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [RA_W-1:0]   ex_wr_addr,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              stall_req
);

    logic [4:0]        conf_q;
    logic              sign_q;
    logic [RA_W-1:0]   rs_addr_q;
    logic [RA_W-1:0]   rt_addr_q;
    logic [RA_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;
    logic              src1_shamt_q;
    logic              src2_imm_q;
    logic              valid_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;

    logic [DATA_W-1:0] rs_capture;
    logic [DATA_W-1:0] rt_capture;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              hazard;
    fwd_sel_t          sel_rs;
    fwd_sel_t          sel_rt;

    // A register being written back this very cycle is not yet visible in
    // the register-file read data, so take it from MEM/WB while capturing.
    assign rs_capture = (memwb_reg_write && (memwb_wr_addr != '0) && (memwb_wr_addr == id_rs_addr))
                        ? memwb_data : id_rs_data;
    assign rt_capture = (memwb_reg_write && (memwb_wr_addr != '0) && (memwb_wr_addr == id_rt_addr))
                        ? memwb_data : id_rt_data;

`ifdef FWD_EN
    id_ex_stage_fwd_unit #(.RA_W(RA_W)) u_fwd_rs (
        .src_addr   (rs_addr_q),
        .near_write (exmem_reg_write),
        .near_addr  (exmem_wr_addr),
        .far_write  (memwb_reg_write),
        .far_addr   (memwb_wr_addr),
        .sel        (sel_rs)
    );

    id_ex_stage_fwd_unit #(.RA_W(RA_W)) u_fwd_rt (
        .src_addr   (rt_addr_q),
        .near_write (exmem_reg_write),
        .near_addr  (exmem_wr_addr),
        .far_write  (memwb_reg_write),
        .far_addr   (memwb_wr_addr),
        .sel        (sel_rt)
    );

    // Operand muxes driven by the forward selects.
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        case (sel_rs)
            FWD_EXMEM: fwd_rs = exmem_result;
            FWD_MEMWB: fwd_rs = memwb_data;
            default:   fwd_rs = rs_data_q;
        endcase
        case (sel_rt)
            FWD_EXMEM: fwd_rt = exmem_result;
            FWD_MEMWB: fwd_rt = memwb_data;
            default:   fwd_rt = rt_data_q;
        endcase
    end

    // Only a load in EX cannot be forwarded in time.
    assign hazard = valid_q && mem_read_q && (wr_addr_q != '0)
                    && ((wr_addr_q == id_rs_addr) || (wr_addr_q == id_rt_addr))
                    && id_valid;
`else
    // Without forwarding the same select logic flags any ID source that a
    // pending writer in EX (near) or EX/MEM (far) will produce.
    id_ex_stage_fwd_unit #(.RA_W(RA_W)) u_fwd_rs (
        .src_addr   (id_rs_addr),
        .near_write (valid_q && reg_write_q),
        .near_addr  (wr_addr_q),
        .far_write  (exmem_reg_write),
        .far_addr   (exmem_wr_addr),
        .sel        (sel_rs)
    );

    id_ex_stage_fwd_unit #(.RA_W(RA_W)) u_fwd_rt (
        .src_addr   (id_rt_addr),
        .near_write (valid_q && reg_write_q),
        .near_addr  (wr_addr_q),
        .far_write  (exmem_reg_write),
        .far_addr   (exmem_wr_addr),
        .sel        (sel_rt)
    );

    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;
    assign hazard = id_valid && ((sel_rs != FWD_REG) || (sel_rt != FWD_REG));

    logic unused_fwd;
    assign unused_fwd = ^{exmem_result, rs_addr_q, rt_addr_q};
`endif

    assign stall_req = hazard;

    // Pipeline register: reset/flush/bubble clear, ext_stall holds, else load.
    always_ff @(posedge clk) begin
        if (reset || flush || (stall_req && !ext_stall)) begin
            conf_q       <= ALU_ADD;
            sign_q       <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            wr_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            src1_shamt_q <= 1'b0;
            src2_imm_q   <= 1'b0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!ext_stall) begin
            conf_q       <= id_alu_conf;
            sign_q       <= id_sign;
            rs_addr_q    <= id_rs_addr;
            rt_addr_q    <= id_rt_addr;
            wr_addr_q    <= id_wr_addr;
            rs_data_q    <= rs_capture;
            rt_data_q    <= rt_capture;
            imm_q        <= id_imm;
            shamt_q      <= id_shamt;
            src1_shamt_q <= id_src1_shamt;
            src2_imm_q   <= id_src2_imm;
            valid_q      <= id_valid;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
        end
    end

    assign alu_conf      = conf_q;
    assign alu_sign      = sign_q;
    assign alu_in1       = src1_shamt_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    assign alu_in2       = src2_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_wr_addr    = wr_addr_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected stage outputs are queued when an
// instruction is driven and compared after the edge that registers it.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_alu_conf;
    logic        id_sign;
    logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_src1_shamt, id_src2_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        ext_stall, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_wr_addr;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_wr_addr;
    logic [31:0] memwb_data;
    logic [4:0]  alu_conf;
    logic        alu_sign;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_wr_addr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        stall_req;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  conf;
        logic        sign;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] store;
        logic [4:0]  wr;
        logic [4:0]  ctl;   // {valid, reg_write, mem_read, mem_write, mem_to_reg}
    } exp_t;

    exp_t sb[$];

    id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_alu_conf(id_alu_conf), .id_sign(id_sign),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_wr_addr(id_wr_addr), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .ext_stall(ext_stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_wr_addr(exmem_wr_addr),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_wr_addr(memwb_wr_addr),
        .memwb_data(memwb_data),
        .alu_conf(alu_conf), .alu_sign(alu_sign),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_wr_addr(ex_wr_addr), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] conf, input logic sign,
                          input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [4:0] wr, input logic [31:0] imm,
                          input logic [4:0] sh, input logic s1, input logic s2,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        id_alu_conf   = conf;  id_sign     = sign;
        id_rs_addr    = rs;    id_rs_data  = rsd;
        id_rt_addr    = rt;    id_rt_data  = rtd;
        id_wr_addr    = wr;    id_imm      = imm;
        id_shamt      = sh;    id_src1_shamt = s1;  id_src2_imm = s2;
        id_reg_write  = rw;    id_mem_read = mr;
        id_mem_write  = mw;    id_mem_to_reg = m2r;
    endtask

    task automatic push(input logic [4:0] conf, input logic sign, input logic [31:0] in1,
                        input logic [31:0] in2, input logic [31:0] store,
                        input logic [4:0] wr, input logic [4:0] ctl);
        exp_t e;
        e.conf = conf; e.sign = sign; e.in1 = in1; e.in2 = in2;
        e.store = store; e.wr = wr; e.ctl = ctl;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        push(ALU_ADD, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".conf"},  {27'b0, alu_conf}, {27'b0, e.conf});
            cmp({tag, ".sign"},  {31'b0, alu_sign}, {31'b0, e.sign});
            cmp({tag, ".in1"},   alu_in1, e.in1);
            cmp({tag, ".in2"},   alu_in2, e.in2);
            cmp({tag, ".store"}, ex_store_data, e.store);
            cmp({tag, ".wr"},    {27'b0, ex_wr_addr}, {27'b0, e.wr});
            cmp({tag, ".ctl"},
                {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                {27'b0, e.ctl});
        end
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b1; ext_stall = 1'b0; flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_wr_addr = 5'd0; exmem_result = 32'h0;
        memwb_reg_write = 1'b0; memwb_wr_addr = 5'd0; memwb_data = 32'h0;
        set_id(ALU_ADD, 0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);

        // Reset held two cycles with a valid instruction in ID.
        push_bubble();
        tick(); tick();
        check("reset");
        cmp("reset.stall", {31'b0, stall_req}, 32'h0);

        // Plain ADD 5 + 7, latency one cycle.
        reset = 1'b0;
        push(ALU_ADD, 0, 32'd5, 32'd7, 32'd7, 5'd3, 5'b11000);
        tick();
        check("add");

        // SLL: In1 is the zero-extended shift amount.
        set_id(ALU_SLL, 0, 5'd0, 32'h0, 5'd2, 32'h1, 5'd6, 32'h0, 5'd3, 1, 0, 1, 0, 0, 0);
        #1 cmp("sll.stall", {31'b0, stall_req}, 32'h0);
        push(ALU_SLL, 0, 32'd3, 32'h1, 32'h1, 5'd6, 5'b11000);
        tick();
        check("sll");

        // ADDI with all-ones immediate, signed.
        set_id(ALU_ADD, 1, 5'd1, 32'h10, 5'd7, 32'h22, 5'd7, 32'hFFFF_FFFF, 5'd0, 0, 1, 1, 0, 0, 0);
        push(ALU_ADD, 1, 32'h10, 32'hFFFF_FFFF, 32'h22, 5'd7, 5'b11000);
        tick();
        check("addi");

        // Capture bypass: MEM/WB writes $8 while ID reads it.
        memwb_reg_write = 1'b1; memwb_wr_addr = 5'd8; memwb_data = 32'hBB;
        set_id(ALU_OR, 0, 5'd8, 32'h99, 5'd9, 32'h33, 5'd10, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        push(ALU_OR, 0, 32'hBB, 32'h33, 32'h33, 5'd10, 5'b11000);
        tick();
        check("bypass");

        // Register 0 is never bypassed, forwarded or a hazard source.
        memwb_wr_addr = 5'd0; memwb_data = 32'hCC;
        exmem_reg_write = 1'b1; exmem_wr_addr = 5'd0; exmem_result = 32'hAA;
        set_id(ALU_XOR, 0, 5'd0, 32'h11, 5'd9, 32'h66, 5'd11, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        #1 cmp("zero_reg.stall", {31'b0, stall_req}, 32'h0);
        push(ALU_XOR, 0, 32'h11, 32'h66, 32'h66, 5'd11, 5'b11000);
        tick();
        check("zero_reg");
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

`ifdef FWD_EN
        // EX/MEM beats MEM/WB; then MEM/WB alone.
        exmem_reg_write = 1'b1; exmem_wr_addr = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_wr_addr = 5'd3; memwb_data = 32'hBB;
        set_id(ALU_ADD, 0, 5'd3, 32'h11, 5'd2, 32'd7, 5'd12, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        push(ALU_ADD, 0, 32'hAA, 32'd7, 32'd7, 5'd12, 5'b11000);
        tick();
        check("fwd_exmem");
        exmem_reg_write = 1'b0;
        push(ALU_ADD, 0, 32'hBB, 32'd7, 32'd7, 5'd12, 5'b11000);
        #1 check("fwd_memwb");
        memwb_reg_write = 1'b0;

        // Load to $4, then a consumer of $4: one bubble, then MEM/WB forward.
        set_id(ALU_ADD, 0, 5'd1, 32'h100, 5'd4, 32'h0, 5'd4, 32'h8, 5'd0, 0, 1, 1, 1, 0, 1);
        push(ALU_ADD, 0, 32'h100, 32'h8, 32'h0, 5'd4, 5'b11101);
        tick();
        check("lw");
        set_id(ALU_ADD, 0, 5'd1, 32'd5, 5'd4, 32'h44, 5'd13, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        #1 cmp("load_use.stall", {31'b0, stall_req}, 32'h1);
        push_bubble();
        tick();
        exmem_reg_write = 1'b1; exmem_wr_addr = 5'd4; exmem_result = 32'h1000;
        #1 check("load_use_bubble");
        cmp("load_use_once.stall", {31'b0, stall_req}, 32'h0);
        push(ALU_ADD, 0, 32'd5, 32'h4444, 32'h4444, 5'd13, 5'b11000);
        tick();
        exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b1; memwb_wr_addr = 5'd4; memwb_data = 32'h4444;
        #1 check("load_use_issue");
        memwb_reg_write = 1'b0;
`else
        // ADD $5 in EX, consumer of $5 waits until $5 reaches MEM/WB.
        set_id(ALU_ADD, 0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd5, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        push(ALU_ADD, 0, 32'd1, 32'd2, 32'd2, 5'd5, 5'b11000);
        tick();
        check("add5");
        set_id(ALU_SUB, 0, 5'd5, 32'h55, 5'd2, 32'd2, 5'd14, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        #1 cmp("raw_ex.stall", {31'b0, stall_req}, 32'h1);
        push_bubble();
        tick();
        exmem_reg_write = 1'b1; exmem_wr_addr = 5'd5; exmem_result = 32'd3;
        #1 check("raw_bubble1");
        cmp("raw_exmem.stall", {31'b0, stall_req}, 32'h1);
        push_bubble();
        tick();
        exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b1; memwb_wr_addr = 5'd5; memwb_data = 32'd3;
        #1 check("raw_bubble2");
        cmp("raw_release.stall", {31'b0, stall_req}, 32'h0);
        push(ALU_SUB, 0, 32'd3, 32'd2, 32'd2, 5'd14, 5'b11000);
        tick();
        memwb_reg_write = 1'b0;
        check("raw_issue");
`endif

        // ext_stall holds the register while ID changes.
        set_id(ALU_AND, 0, 5'd1, 32'hF0, 5'd2, 32'h0F, 5'd15, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        push(ALU_AND, 0, 32'hF0, 32'h0F, 32'h0F, 5'd15, 5'b11000);
        tick();
        check("and");
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(ALU_NOR, 1, 5'd20 + 5'(i), 32'(i + 100), 5'd21, 32'h5A, 5'd22,
                   32'h1234, 5'd9, 1, 1, 0, 1, 1, 1);
            push(ALU_AND, 0, 32'hF0, 32'h0F, 32'h0F, 5'd15, 5'b11000);
            tick();
            check("stall_hold");
        end

        // Flush during ext_stall still clears.
        flush = 1'b1;
        push_bubble();
        tick();
        check("flush_in_stall");
        flush = 1'b0; ext_stall = 1'b0;

        // Load in EX, consumer in ID and a flush in the same cycle.
        set_id(ALU_ADD, 0, 5'd1, 32'h200, 5'd16, 32'h0, 5'd16, 32'h4, 5'd0, 0, 1, 1, 1, 0, 1);
        push(ALU_ADD, 0, 32'h200, 32'h4, 32'h0, 5'd16, 5'b11101);
        tick();
        check("lw2");
        set_id(ALU_ADD, 0, 5'd16, 32'h77, 5'd2, 32'd2, 5'd17, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        flush = 1'b1;
        #1 cmp("flush_hazard.stall", {31'b0, stall_req}, 32'h1);
        push_bubble();
        tick();
        flush = 1'b0;
        check("flush_hazard");
        cmp("after_flush.stall", {31'b0, stall_req}, 32'h0);
        push(ALU_ADD, 0, 32'h77, 32'd2, 32'd2, 5'd17, 5'b11000);
        tick();
        check("reissue");

        // id_valid=0: fields captured, ex_valid low.
        id_valid = 1'b0;
        set_id(ALU_SLT, 1, 5'd1, 32'd9, 5'd2, 32'd8, 5'd18, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
        push(ALU_SLT, 1, 32'd9, 32'd8, 32'd8, 5'd18, 5'b01000);
        tick();
        check("invalid");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
